// File: rtl/mul_seq_ctrl.sv
// Sequential shift-add multiplier sequencer that borrows the shared ALU adder.
// One partial product per RUN cycle; start/busy/done handshake toward control.
module mul_seq_ctrl #(
    parameter int WIDTH      = 64,
    parameter bit EARLY_TERM = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_cout
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] acc_q,     acc_d;
    logic [WIDTH-1:0] m_q,       m_d;
    logic [WIDTH-1:0] q_q,       q_d;
    logic [CW-1:0]    count_q,   count_d;
    logic             lost_q,    lost_d;
    logic             ovf_int_q, ovf_int_d;
    logic [WIDTH-1:0] result_q,  result_d;
    logic             ovf_q,     ovf_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             last_iter;

    // NOTE: every *_d gets a default before the case so no path leaves a latch.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        m_d       = m_q;
        q_d       = q_q;
        count_d   = count_q;
        lost_d    = lost_q;
        ovf_int_d = ovf_int_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        last_iter = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    m_d       = op_a;
                    q_d       = op_b;
                    acc_d     = '0;
                    count_d   = '0;
                    lost_d    = 1'b0;
                    ovf_int_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = RUN;
                end
            end

            RUN: begin
                // lost remembers multiplicand bits shifted past the top; any
                // later partial product then carries weight >= 2^WIDTH.
                if (q_q[0]) begin
                    acc_d     = add_s;
                    ovf_int_d = ovf_int_q | add_cout | lost_q;
                end
                lost_d  = lost_q | m_q[WIDTH-1];
                m_d     = m_q << 1;
                q_d     = q_q >> 1;
                count_d = count_q + CW'(1);

                last_iter = (count_q == CW'(WIDTH - 1)) ||
                            (EARLY_TERM && ((q_q >> 1) == '0));
                if (last_iter) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = acc_d;
                    ovf_d    = ovf_int_d;
                end
            end

            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state is only ever updated here with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            m_q       <= '0;
            q_q       <= '0;
            count_q   <= '0;
            lost_q    <= 1'b0;
            ovf_int_q <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            m_q       <= m_d;
            q_q       <= q_d;
            count_q   <= count_d;
            lost_q    <= lost_d;
            ovf_int_q <= ovf_int_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign add_a   = acc_q;
    assign add_b   = m_q;
    assign add_cin = 1'b0;
    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: dut 0 runs with early termination,
// dut 1 always runs the full WIDTH iterations. Each has its own adder model.
module tb_mul_seq_ctrl;

    localparam int W = 64;
    localparam logic [W-1:0] ALL1 = {W{1'b1}};
    localparam logic [W-1:0] TOP  = {1'b1, {(W-1){1'b0}}};

    logic         clk;
    logic         rst_n;
    logic [1:0]   start;
    logic [W-1:0] op_a    [2];
    logic [W-1:0] op_b    [2];
    logic [1:0]   busy;
    logic [1:0]   done;
    logic [W-1:0] result  [2];
    logic [1:0]   ovf;
    logic [W-1:0] add_a   [2];
    logic [W-1:0] add_b   [2];
    logic [1:0]   add_cin;
    logic [W-1:0] add_s   [2];
    logic [1:0]   add_cout;

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ripple-carry adder stand-ins.
    assign {add_cout[0], add_s[0]} = {1'b0, add_a[0]} + {1'b0, add_b[0]} + {{W{1'b0}}, add_cin[0]};
    assign {add_cout[1], add_s[1]} = {1'b0, add_a[1]} + {1'b0, add_b[1]} + {{W{1'b0}}, add_cin[1]};

    mul_seq_ctrl #(.WIDTH(W), .EARLY_TERM(1'b1)) u_dut_et (
        .clk(clk), .rst_n(rst_n), .start(start[0]),
        .op_a(op_a[0]), .op_b(op_b[0]),
        .busy(busy[0]), .done(done[0]), .result(result[0]), .ovf(ovf[0]),
        .add_a(add_a[0]), .add_b(add_b[0]), .add_cin(add_cin[0]),
        .add_s(add_s[0]), .add_cout(add_cout[0])
    );

    mul_seq_ctrl #(.WIDTH(W), .EARLY_TERM(1'b0)) u_dut_full (
        .clk(clk), .rst_n(rst_n), .start(start[1]),
        .op_a(op_a[1]), .op_b(op_b[1]),
        .busy(busy[1]), .done(done[1]), .result(result[1]), .ovf(ovf[1]),
        .add_a(add_a[1]), .add_b(add_b[1]), .add_cin(add_cin[1]),
        .add_s(add_s[1]), .add_cout(add_cout[1])
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One full operation: launch, measure RUN length and busy span, check outputs.
    task automatic run_mul(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int exp_n, input logic [W-1:0] exp_r, input logic exp_o,
                           input string tag);
        int lat;
        int busy_cycles;
        @(negedge clk);
        op_a[d]  = a;
        op_b[d]  = b;
        start[d] = 1'b1;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
        lat = 0;
        busy_cycles = busy[d] ? 1 : 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (busy[d]) busy_cycles++;
            if (done[d]) begin
                lat = i;
                break;
            end
        end
        check({tag, "_lat"},    W'(lat),         W'(exp_n));
        check({tag, "_busy"},   W'(busy_cycles), W'(exp_n + 1));
        check({tag, "_result"}, result[d],       exp_r);
        check({tag, "_ovf"},    W'(ovf[d]),      W'(exp_o));
        @(posedge clk);
        #1;
        check({tag, "_idle"},   W'({busy[d], done[d]}), W'(0));
        check({tag, "_hold"},   result[d],       exp_r);
    endtask

    initial begin
        int dones;
        rst_n    = 1'b0;
        start    = 2'b00;
        op_a[0]  = '0; op_b[0] = '0;
        op_a[1]  = '0; op_b[1] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_busy",   W'(busy[0]), W'(0));
        check("rst_done",   W'(done[0]), W'(0));
        check("rst_result", result[0],   W'(0));
        check("rst_ovf",    W'(ovf[0]),  W'(0));
        check("rst_add_cin", W'(add_cin[0]), W'(0));

        // Early-termination instance.
        run_mul(0, W'(7),  W'(6),  3,  W'(42),       1'b0, "et_7x6");
        run_mul(0, ALL1,   W'(1),  1,  ALL1,         1'b0, "et_max_x1");
        run_mul(0, TOP,    W'(2),  2,  W'(0),        1'b1, "et_lost");
        run_mul(0, TOP | W'(1), W'(3), 2, TOP | W'(3), 1'b1, "et_top3");
        run_mul(0, W'(5),  W'(0),  1,  W'(0),        1'b0, "et_b0");
        run_mul(0, W'(0),  TOP,    64, W'(0),        1'b0, "et_a0_top");
        run_mul(0, ALL1,   ALL1,   64, W'(1),        1'b1, "et_max_sq");
        run_mul(0, W'(64'h1_0000_0000), W'(64'h1_0000_0000), 33, W'(0), 1'b1, "et_2p64");

        // Fixed-length instance.
        run_mul(1, W'(7),  W'(6),  64, W'(42),       1'b0, "full_7x6");
        run_mul(1, W'(0),  W'(0),  64, W'(0),        1'b0, "full_0x0");
        run_mul(1, W'(64'h1234_5678), W'(64'h100), 64, W'(64'h12_3456_7800), 1'b0, "full_shift");

        // start held high: each op takes 4 busy cycles, then one idle cycle.
        @(negedge clk);
        op_a[0]  = W'(7);
        op_b[0]  = W'(6);
        start[0] = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_busy_%0d", i), W'(busy[0]), W'((i % 5) != 0));
            check($sformatf("hold_done_%0d", i), W'(done[0]), W'((i % 5) == 4));
        end
        start[0] = 1'b0;
        check("hold_result", result[0], W'(42));
        repeat (2) @(posedge clk);

        // A second start during RUN must be ignored: 5 * 0x80 = 640, n = 8.
        @(negedge clk);
        op_a[0]  = W'(5);
        op_b[0]  = W'(64'h80);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        op_a[0]  = W'(9);
        op_b[0]  = W'(9);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done[0]) dones++;
        end
        check("midrun_dones",  W'(dones),     W'(1));
        check("midrun_result", result[0],     W'(640));
        check("midrun_ovf",    W'(ovf[0]),    W'(0));
        check("midrun_idle",   W'(busy[0]),   W'(0));

        // Reset in the middle of a 64-cycle multiply aborts it silently.
        @(negedge clk);
        op_a[0]  = W'(3);
        op_b[0]  = TOP;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("abort_busy_pre", W'(busy[0]), W'(1));
        rst_n = 1'b0;
        #1;
        check("abort_busy",   W'(busy[0]),  W'(0));
        check("abort_done",   W'(done[0]),  W'(0));
        check("abort_result", result[0],    W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (done[0] || busy[0]) dones++;
        end
        check("abort_no_done", W'(dones), W'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
